mio_bus_ctrl: RTL

Memory/IO bus controller sitting directly downstream of the multi-cycle CPU control FSM. It consumes the FSM's memory strobes (MemRead, MemWrite, CPU_MIO) and the datapath address/write data, decodes each access to block RAM or the peripheral bus, and inserts wait states. It returns read data plus the one-cycle `MIO_ready` pulse that advances the FSM out of instruction-fetch and memory states.

---
 rtl/mio_bus_ctrl_pkg.sv | 24 ++
 rtl/mio_bus_ctrl_if.sv | 36 +++
 rtl/mio_wait_cnt.sv | 28 ++
 rtl/mio_bus_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory/IO bus controller: FSM encoding,
// the IO address region and the data returned by an aborted IO read.
package mio_bus_ctrl_pkg;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_RAM_WAIT_ENC = 2'd1;
  localparam logic [1:0] ST_IO_WAIT_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_RAM_WAIT = ST_RAM_WAIT_ENC,
    ST_IO_WAIT  = ST_IO_WAIT_ENC,
    ST_DONE     = ST_DONE_ENC
  } state_t;

  localparam logic [3:0]  IO_REGION    = 4'hF;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  function automatic logic is_io_addr(input logic [31:0] a);
    return a[31:28] == IO_REGION;
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU, RAM and peripheral signals of the bus controller. The controller
// uses the slave view; the CPU/memory/peripheral environment uses master.
interface mio_bus_ctrl_if #(parameter int RAM_AW = 10);

  logic              MemRead;
  logic              MemWrite;
  logic              CPU_MIO;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              MIO_ready;
  logic              bus_err;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              io_rd;
  logic              io_wr;
  logic [27:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ack;

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, addr, wdata, ram_dout, io_rdata, io_ack,
    output rdata, MIO_ready, bus_err, ram_we, ram_addr, ram_din,
           io_rd, io_wr, io_addr, io_wdata
  );

  modport master (
    output MemRead, MemWrite, CPU_MIO, addr, wdata, ram_dout, io_rdata, io_ack,
    input  rdata, MIO_ready, bus_err, ram_we, ram_addr, ram_din,
           io_rd, io_wr, io_addr, io_wdata
  );

endinterface

// File: rtl/mio_wait_cnt.sv
// Loadable down-counter with a zero flag; shared by the RAM wait-state
// and IO timeout paths of the bus controller.
module mio_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU strobes to block RAM or the
// peripheral bus, inserts wait states and returns a one-cycle ready.
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int RAM_WAIT   = 1,
  parameter int IO_TIMEOUT = 16,
  parameter int RAM_AW     = 10
) (
  input  logic           clk,
  input  logic           reset,
  mio_bus_ctrl_if.slave  bus
);

  localparam logic [7:0] RAM_LOAD = 8'(RAM_WAIT);
  localparam logic [7:0] IO_LOAD  = 8'(IO_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              write_reg;
  logic [RAM_AW-1:0] ram_addr_reg;
  logic [31:0]       ram_din_reg;
  logic [31:0]       rdata_reg;
  logic [27:0]       io_addr_reg;
  logic [31:0]       io_wdata_reg;
  logic              io_rd_reg, io_wr_reg;
  logic              bus_err_reg;

  logic       req_valid, req_both;
  logic       accept_ram, accept_io;
  logic       ram_done, io_done, io_expire;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [7:0] cnt_val;

  mio_wait_cnt #(.W(8)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_val    = RAM_LOAD;
    cnt_dec    = 1'b0;
    accept_ram = 1'b0;
    accept_io  = 1'b0;
    ram_done   = 1'b0;
    io_done    = 1'b0;
    io_expire  = 1'b0;
    req_valid  = !reset && bus.CPU_MIO && (bus.MemRead ^ bus.MemWrite);
    req_both   = bus.CPU_MIO && bus.MemRead && bus.MemWrite;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_load = 1'b1;
          if (is_io_addr(bus.addr)) begin
            accept_io  = 1'b1;
            cnt_val    = IO_LOAD;
            state_next = ST_IO_WAIT;
          end else begin
            accept_ram = 1'b1;
            state_next = ST_RAM_WAIT;
          end
        end
      end
      ST_RAM_WAIT: begin
        if (cnt_zero) begin
          ram_done   = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_IO_WAIT: begin
        // An ack in the expiry cycle still completes the access cleanly.
        if (bus.io_ack) begin
          io_done    = 1'b1;
          state_next = ST_DONE;
        end else if (cnt_zero) begin
          io_expire  = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg    <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      rdata_reg    <= '0;
      io_addr_reg  <= '0;
      io_wdata_reg <= '0;
      io_rd_reg    <= 1'b0;
      io_wr_reg    <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      if (accept_ram || accept_io) write_reg <= bus.MemWrite;
      if (accept_ram) begin
        ram_addr_reg <= bus.addr[RAM_AW+1:2];
        ram_din_reg  <= bus.wdata;
      end
      if (accept_io) begin
        io_addr_reg  <= bus.addr[27:0];
        io_wdata_reg <= bus.wdata;
        io_rd_reg    <= bus.MemRead;
        io_wr_reg    <= bus.MemWrite;
      end
      if (io_done || io_expire) begin
        io_rd_reg <= 1'b0;
        io_wr_reg <= 1'b0;
      end
      if (!write_reg) begin
        if (ram_done)  rdata_reg <= bus.ram_dout;
        if (io_done)   rdata_reg <= bus.io_rdata;
        if (io_expire) rdata_reg <= BUS_ERR_DATA;
      end
      if (io_expire || ((state_reg == ST_IDLE) && req_both)) bus_err_reg <= 1'b1;
    end
  end

  // The RAM sees the live request in the accepting cycle so its synchronous
  // read is already under way when the FSM enters RAM_WAIT.
  assign bus.ram_we    = accept_ram && bus.MemWrite;
  assign bus.ram_addr  = accept_ram ? bus.addr[RAM_AW+1:2] : ram_addr_reg;
  assign bus.ram_din   = accept_ram ? bus.wdata : ram_din_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.MIO_ready = (state_reg == ST_DONE);
  assign bus.bus_err   = bus_err_reg;
  assign bus.io_rd     = io_rd_reg;
  assign bus.io_wr     = io_wr_reg;
  assign bus.io_addr   = io_addr_reg;
  assign bus.io_wdata  = io_wdata_reg;

endmodule
